// File: rtl/varredura_colunas_if.sv
// Handshake and display bus between the panel frame source and the column-scan controller.
// The source uses the master modport, and the scan controller uses the slave modport.
interface varredura_colunas_if;
  logic        run;
  logic        load;
  logic [34:0] frame_in;
  logic        sel1;
  logic        sel2;
  logic        sel3;
  logic        enable;
  logic [4:0]  rows;
  logic        pending;
  logic        frame_start;

  modport master (
    output run, load, frame_in,
    input  sel1, sel2, sel3, enable, rows, pending, frame_start
  );

  modport slave (
    input  run, load, frame_in,
    output sel1, sel2, sel3, enable, rows, pending, frame_start
  );
endinterface

// File: rtl/varredura_colunas.sv
// Column-scan controller for a 7x5 LED matrix: time-multiplexes a double-buffered
// 35-bit frame one column per PRESCALE-cycle slot, blanking the first BLANK cycles.
module varredura_colunas #(
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 4
) (
  input  logic                clk,
  input  logic                reset,
  varredura_colunas_if.slave  bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] BLANK_V    = PW'(BLANK);

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    col_q, col_d;
  logic [34:0]   active_q, active_d;
  logic [34:0]   shadow_q, shadow_d;
  logic          pending_q, pending_d;
  logic          frame_start_q, frame_start_d;

  logic          slot_end;
  logic          wrap;
  logic          xfer;
  logic          en;
  logic [4:0]    col_rows;

  always_comb begin
    slot_end      = bus.run && (presc_q == PRESC_LAST);
    wrap          = slot_end && (col_q == 3'd6);
    // Frame boundary or frozen (blanked) display: both are tear-free points to swap buffers.
    xfer          = wrap || (!bus.run && pending_q);

    presc_d       = presc_q;
    col_d         = col_q;
    active_d      = active_q;
    shadow_d      = shadow_q;
    pending_d     = pending_q;
    frame_start_d = wrap;

    if (bus.run) begin
      if (slot_end) begin
        presc_d = '0;
        col_d   = wrap ? 3'd0 : col_q + 3'd1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    // A load coinciding with a swap point bypasses the shadow and shows immediately.
    if (bus.load) begin
      shadow_d = bus.frame_in;
      if (xfer) begin
        active_d  = bus.frame_in;
        pending_d = 1'b0;
      end else begin
        pending_d = 1'b1;
      end
    end else if (xfer && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q       <= '0;
      col_q         <= '0;
      active_q      <= '0;
      shadow_q      <= '0;
      pending_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      col_q         <= col_d;
      active_q      <= active_d;
      shadow_q      <= shadow_d;
      pending_q     <= pending_d;
      frame_start_q <= frame_start_d;
    end
  end

  always_comb begin
    col_rows = '0;
    for (int c = 0; c < 7; c++) begin
      if (col_q == 3'(c)) col_rows = active_q[5*c +: 5];
    end
  end

  assign en              = bus.run && (presc_q >= BLANK_V);
  assign bus.sel1        = col_q[2];
  assign bus.sel2        = col_q[1];
  assign bus.sel3        = col_q[0];
  assign bus.enable      = en;
  assign bus.rows        = en ? col_rows : 5'b00000;
  assign bus.pending     = pending_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: doc/varredura_colunas.md
Name: varredura_colunas

Overview:
Column-scan controller for the LED-matrix electronic panel (7 columns x 5 rows).
- Time-multiplexes a 35-bit frame one column at a time.
- Drives the 3-bit column select, with a blanking-aware enable, to the downstream 3-to-7 active-low column decoder.
- Drives the matching 5-bit row pattern.
- Frames are double-buffered so new frames only take effect at a frame boundary, with no tearing.

Parameters:
PRESCALE, 50000, clock cycles per column slot (must be >= 2)
BLANK, 4, cycles at the start of each slot with enable low to suppress ghosting (1 <= BLANK < PRESCALE)

Ports:
clk  input  1  system clock, single clock domain, rising edge
reset  input  1  synchronous, active-high reset
run  input  1  1 = scanning; 0 = freeze scan, display blanked
load  input  1  one-cycle strobe; captures frame_in into the shadow buffer
frame_in  input  35  new frame; column c occupies bits [5c+4:5c], bit 5c = row 0
sel1  output  1  column index bit 2 (MSB)
sel2  output  1  column index bit 1
sel3  output  1  column index bit 0 (LSB)
enable  output  1  column drive enable to the decoder
rows  output  5  row pattern for the current column, active-high
pending  output  1  shadow holds a frame not yet displayed
frame_start  output  1  one-cycle pulse when the column index wraps 6->0

Behaviour:
State registers:
- presc: 0..PRESCALE-1.
- col: 0..6.
- active[34:0], shadow[34:0], pending, frame_start.

Reset (synchronous, highest priority):
- presc=0, col=0, active=0, shadow=0, pending=0, frame_start=0.
- Resulting outputs: sel=000, enable=0, rows=00000, pending=0, frame_start=0.
- Reset mid-frame discards any pending frame.

Outputs:
- {sel1,sel2,sel3} = col, combinational from registers.
- enable = run AND (presc >= BLANK).
- rows = enable ? active[5*col+4 : 5*col] : 5'b00000.

Scan, when run=1:
- presc increments each cycle.
- At presc==PRESCALE-1: presc -> 0 and col -> col+1.
- col wraps 6 -> 0; values 7 never occur.
- Each slot is exactly PRESCALE cycles: enable low for BLANK cycles, then high for PRESCALE-BLANK cycles.

Wrap cycle (the edge where col goes 6 -> 0):
- frame_start=1 for the following cycle, 0 otherwise.
- If pending=1: active <= shadow, pending <= 0.

Load:
- load=1 captures shadow <= frame_in and sets pending <= 1.
- A second load before transfer overwrites shadow (latest wins); pending stays 1.
- Load on the wrap edge: active <= frame_in directly, shadow <= frame_in, pending stays/becomes 0. The new frame displays from column 0 of the new frame.

When run=0:
- presc and col hold; enable=0, rows=0.
- If pending=1 and load=0: active <= shadow and pending <= 0 on the next edge. The display is idle, so there is no tearing.
- frame_start stays 0.
- When run returns to 1, scanning resumes from the held presc and col.

Simultaneous load and run=0 transfer: the load wins; its data goes to both shadow and active, and pending=0.

No other state. All arithmetic is unsigned; presc width is clog2(PRESCALE).

Test Plan:
(Bench uses PRESCALE=8, BLANK=2.)
1. Reset, then run=1 -> sel=000 with enable=0 for 2 cycles then 1 for 6. sel=001 at cycle 8, sel=110 at cycle 48. At cycle 56 sel=000 and frame_start=1 for exactly one cycle. Period is 56 cycles.
2. After 1 frame with active=0, pulse load with frame_in column3=5'b10101 (others 0) at cycle 10 -> pending=1. rows stays 00000 during column 3 of the current frame. After the wrap, pending=0 and rows=10101 during column 3 slot cycles 2-7.
3. load asserted exactly on the wrap edge with column0=5'b11111 -> pending never rises. rows=11111 from cycle 2 of the very next column-0 slot.
4. Mid-slot (presc=5, col=4) with pending=1, drop run for 10 cycles -> enable=0 and rows=0 immediately, sel holds 100. pending clears one cycle later. When run=1 again, the slot resumes at presc=5 with enable=1 and the new data.
5. Two loads (0x0_0000_001F then 0x7_C000_0000) before the wrap -> the frame after the wrap shows only the second pattern (column 6=11111, column 0=00000).
6. Assert reset mid-frame (col=5, pending=1) -> next edge: sel=000, enable=0, rows=0, pending=0, active=0. The scan restarts from presc=0 when reset is released with run=1.
